// File: rtl/uart_pkg.sv
// Shared definitions for the stream UART transmitter.
// - uart_state_e : transmitter FSM states
// - Def*         : default frame configuration (8N1)
// - frame_bits() : total bit slots per frame (start + data + parity + stop)
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned DefDataBits  = 8;
  localparam int unsigned DefStopBits  = 1;
  localparam int unsigned DefParityEn  = 0;
  localparam int unsigned DefParityOdd = 0;

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick generator.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : reload the counter from load (asserted on the stream handshake)
//   load       : bit period minus one, in clk cycles
//   tick       : high for one cycle at the end of every period of load+1 cycles
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] load,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;

  // Counts down from load to 0; the tick cycle reloads, so the period is load+1
  // even for an all-ones load.
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= load;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/stream_uart_tx.sv
// Stream-sink UART transmitter: accepts one word per valid/ready handshake and
// serialises it as start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   io_push_valid     : stream valid
//   io_push_ready     : stream ready, high only in idle
//   io_push_payload   : word to transmit
//   io_clock_divider  : bit period minus one, captured on the handshake
//   io_txd            : registered serial output, idle high
//   io_busy           : high while a frame is in flight
module stream_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned STOP_BITS  = DefStopBits,
  parameter int unsigned PARITY_EN  = DefParityEn,
  parameter int unsigned PARITY_ODD = DefParityOdd
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_push_valid,
  output logic                 io_push_ready,
  input  logic [DATA_BITS-1:0] io_push_payload,
  input  logic [DIV_WIDTH-1:0] io_clock_divider,
  output logic                 io_txd,
  output logic                 io_busy
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);
  localparam logic LastStop = (STOP_BITS == 2);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 parity_q;
  logic                 txd_q;

  logic                 handshake;
  logic                 tick;
  logic [DIV_WIDTH-1:0] baud_load;

  assign io_push_ready = (state_q == StIdle);
  assign io_busy       = (state_q != StIdle);
  assign io_txd        = txd_q;
  assign handshake     = io_push_valid && io_push_ready;

  // The counter is cleared in the same edge that captures div_q, so it must see
  // the incoming divider rather than the stale register.
  assign baud_load = handshake ? io_clock_divider : div_q;

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(handshake),
    .load (baud_load),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (handshake) begin
            state_q    <= StStart;
            shift_q    <= io_push_payload;
            div_q      <= io_clock_divider;
            parity_q   <= (^io_push_payload) ^ 1'(PARITY_ODD);
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b0;
          end
        end
        StStart: begin
          if (tick) begin
            state_q <= StData;
            txd_q   <= shift_q[0];
          end
        end
        StData: begin
          if (tick) begin
            if (bit_cnt_q == LastBit) begin
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                txd_q   <= parity_q;
              end else begin
                state_q <= StStop;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
              shift_q   <= shift_q >> 1;
              // Drive the next bit now so txd stays registered and aligned to the tick.
              txd_q     <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (tick) begin
            state_q <= StStop;
            txd_q   <= 1'b1;
          end
        end
        StStop: begin
          if (tick) begin
            if (stop_cnt_q == LastStop) begin
              state_q <= StIdle;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_uart_tx.sv
// Bench for stream_uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share data and
// divider inputs; sel picks which one is driven and observed. Stimulus pushes the
// expected line waveform of each frame into a queue; a monitor watches txd and
// checks every cycle of every bit slot against the popped entry.
module tb_stream_uart_tx;

  logic        clk;
  logic        reset;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [3:0]  busy;
  logic [3:0]  txd;
  logic [7:0]  payload;
  logic [15:0] div;
  logic [1:0]  sel;

  logic txd_m, ready_m, busy_m;
  assign txd_m   = txd[sel];
  assign ready_m = ready[sel];
  assign busy_m  = busy[sel];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          p;
    logic [7:0]  data;
    bit          abort_ok;
  } frame_t;

  frame_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
  u_dut0 (
    .clk(clk), .reset(reset), .io_push_valid(valid[0]), .io_push_ready(ready[0]),
    .io_push_payload(payload), .io_clock_divider(div), .io_txd(txd[0]), .io_busy(busy[0])
  );

  stream_uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0))
  u_dut1 (
    .clk(clk), .reset(reset), .io_push_valid(valid[1]), .io_push_ready(ready[1]),
    .io_push_payload(payload), .io_clock_divider(div), .io_txd(txd[1]), .io_busy(busy[1])
  );

  stream_uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
  u_dut2 (
    .clk(clk), .reset(reset), .io_push_valid(valid[2]), .io_push_ready(ready[2]),
    .io_push_payload(payload), .io_clock_divider(div), .io_txd(txd[2]), .io_busy(busy[2])
  );

  stream_uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0))
  u_dut3 (
    .clk(clk), .reset(reset), .io_push_valid(valid[3]), .io_push_ready(ready[3]),
    .io_push_payload(payload), .io_clock_divider(div), .io_txd(txd[3]), .io_busy(busy[3])
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called at a negedge. Presents the word, waits for ready, queues the expected
  // frame and returns at the negedge after the handshake edge with valid still high.
  task automatic send(input logic [7:0] b, input logic [15:0] d, input logic par,
                      input bit abort_ok, output int hs_cyc);
    frame_t f;
    int     n;
    int     w;
    int     stops;
    payload    = b;
    div        = d;
    valid      = '0;
    valid[sel] = 1'b1;
    w = 0;
    while (!ready_m && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!ready_m) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout actual=ready_low required=ready_high");
      valid  = '0;
      hs_cyc = -1;
      return;
    end
    hs_cyc = cyc;
    f.bits = '0;
    n = 0;
    f.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      f.bits[n] = b[i];
      n++;
    end
    if (sel == 2'd1 || sel == 2'd2) begin
      f.bits[n] = par;
      n++;
    end
    stops = (sel == 2'd3) ? 2 : 1;
    for (int s = 0; s < stops; s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits    = n;
    f.p        = int'(d) + 1;
    f.data     = b;
    f.abort_ok = abort_ok;
    exp_q.push_back(f);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy_m && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("wait_idle_busy", int'(busy_m), 0);
  endtask

  // Monitor: detects a start edge, then checks each cycle of each bit slot.
  initial begin
    logic       prev;
    frame_t     f;
    bit         aborted;
    int         bad;
    int         fid;
    logic [7:0] got;
    prev = 1'b1;
    fid  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && !txd_m) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=start_bit required=idle_line");
          prev = txd_m;
        end else begin
          f       = exp_q.pop_front();
          aborted = 1'b0;
          got     = '0;
          for (int b = 0; b < f.nbits && !aborted; b++) begin
            bad = 0;
            for (int c = 0; c < f.p; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (reset) begin
                aborted = 1'b1;
                break;
              end
              if (c == 0 && b >= 1 && b <= 8) got[b-1] = txd_m;
              if (txd_m !== f.bits[b]) bad++;
            end
            if (!aborted) check($sformatf("frame%0d_bit%0d_wrong_cycles", fid, b), bad, 0);
          end
          if (aborted) begin
            if (!f.abort_ok) check($sformatf("frame%0d_aborted", fid), 1, 0);
          end else begin
            check($sformatf("frame%0d_decoded_byte", fid), int'(got), int'(f.data));
          end
          fid++;
          prev = 1'b1;
        end
      end else begin
        prev = txd_m;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0, h1, h2, nb, nr;
    reset   = 1'b1;
    valid   = '0;
    payload = '0;
    div     = '0;
    sel     = 2'd0;

    // Reset values.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_txd%0d", i), int'(txd[i]), 1);
      check($sformatf("rst_ready%0d", i), int'(ready[i]), 1);
      check($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Idle with valid low.
    for (int i = 0; i < 20; i++) begin
      check("idle_txd", int'(txd_m), 1);
      check("idle_ready", int'(ready_m), 1);
      check("idle_busy", int'(busy_m), 0);
      @(negedge clk);
    end

    // 0x55, divider 3, 8N1: busy and not-ready for exactly 40 cycles.
    send(8'h55, 16'd3, 1'b0, 1'b0, h0);
    valid = '0;
    nb = 0;
    nr = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_m) nb++;
      if (!ready_m) nr++;
      @(negedge clk);
    end
    check("busy_cycles_0x55", nb, 40);
    check("ready_low_cycles_0x55", nr, 40);
    wait_idle();

    // Back-to-back at divider 0: handshakes 11 cycles apart.
    send(8'hA3, 16'd0, 1'b0, 1'b0, h1);
    send(8'h0F, 16'd0, 1'b0, 1'b0, h2);
    valid = '0;
    check("b2b_spacing_div0", h2 - h1, 11);
    wait_idle();

    // Even parity of 0x07 is 1, odd parity is 0; divider 1.
    sel = 2'd1;
    @(negedge clk);
    send(8'h07, 16'd1, 1'b1, 1'b0, h0);
    valid = '0;
    wait_idle();
    sel = 2'd2;
    @(negedge clk);
    send(8'h07, 16'd1, 1'b0, 1'b0, h0);
    valid = '0;
    wait_idle();

    // Divider changes mid-frame; the frame in flight keeps P=4, the next uses P=10.
    sel = 2'd0;
    @(negedge clk);
    send(8'h3C, 16'd3, 1'b0, 1'b0, h0);
    valid = '0;
    repeat (10) @(negedge clk);
    div = 16'd9;
    wait_idle();
    send(8'hC3, 16'd9, 1'b0, 1'b0, h0);
    valid = '0;
    wait_idle();

    // Two stop bits, divider 2: (1+8+2)*3+1 = 34 cycles between handshakes.
    sel = 2'd3;
    @(negedge clk);
    send(8'h81, 16'd2, 1'b0, 1'b0, h1);
    send(8'h42, 16'd2, 1'b0, 1'b0, h2);
    valid = '0;
    check("b2b_spacing_2stop", h2 - h1, 34);
    wait_idle();

    // Reset mid-frame while data bit 1 (0) is on the line.
    sel = 2'd0;
    @(negedge clk);
    send(8'hF0, 16'd3, 1'b0, 1'b1, h0);
    valid = '0;
    repeat (9) @(negedge clk);
    check("pre_reset_txd", int'(txd_m), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("reset_async_txd", int'(txd_m), 1);
    check("reset_async_busy", int'(busy_m), 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", int'(ready_m), 1);
    check("post_reset_txd", int'(txd_m), 1);
    repeat (20) @(negedge clk);
    check("post_reset_idle_txd", int'(txd_m), 1);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
